// File: rtl/i2c_reg_arb_pkg.sv
// Shared types and constants for the I2C register-port arbiter.
// The response struct carries read data and the out-of-range flag.
package i2c_reg_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } resp_t;

endpackage

// File: rtl/i2c_reg_access_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. The pointer names the requester that wins a tie
// and moves to the other requester whenever a served transaction completes.
module rr_arbiter2
    import i2c_reg_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               update_i,
    input  logic               served_id_i,
    output logic               grant_valid_o,
    output logic               grant_id_o
);

    logic ptr_q;
    logic ptr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i) begin
            ptr_d = ~served_id_i;
        end
    end

    always_comb begin
        grant_valid_o = |req_i;
        grant_id_o    = 1'b0;
        case (req_i)
            2'b10:   grant_id_o = 1'b1;
            2'b11:   grant_id_o = ptr_q;
            default: grant_id_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/i2c_reg_access_arbiter.sv
// Shares the I2C register-file port between the host slave (0) and debug port (1).
// One access per three cycles: handshake, one-hot strobe, response.
//
// state  | meaning
// IDLE   | arbitrate; ready pulses for the granted requester
// ACCESS | one-hot write/read strobe from latched request; capture read data
// RESP   | response pulse to the granted requester; advance pointer
module i2c_reg_access_arbiter
    import i2c_reg_arb_pkg::*;
#(
    parameter int REGS         = 9,
    parameter int ADDRESSWIDTH = $clog2(REGS)
)
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic                            resp_err,
    output logic [DATA_WIDTH-1:0]           reg_data_in,
    output logic [REGS-1:0]                 reg_write_en,
    output logic [REGS-1:0]                 reg_read_en,
    input  logic [REGS*DATA_WIDTH-1:0]      reg_data_out
);

    localparam logic [ADDRESSWIDTH:0] REGS_W = (ADDRESSWIDTH+1)'(REGS);

    state_t                  state_q;
    state_t                  state_d;
    logic                    gid_q;
    logic                    wr_q;
    logic [ADDRESSWIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    resp_t                   resp_q;

    logic                    grant_valid;
    logic                    grant_id;
    logic                    handshake;
    logic                    in_range;
    logic [ADDRESSWIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [DATA_WIDTH-1:0]   rd_word;

    rr_arbiter2 u_rr (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req_valid),
        .update_i      (state_q == RESP),
        .served_id_i   (gid_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    assign handshake = (state_q == IDLE) && grant_valid;
    assign sel_addr  = grant_id ? req_addr[2*ADDRESSWIDTH-1:ADDRESSWIDTH]
                                : req_addr[ADDRESSWIDTH-1:0];
    assign sel_wdata = grant_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                : req_wdata[DATA_WIDTH-1:0];
    assign in_range  = ({1'b0, addr_q} < REGS_W);

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < REGS; k++) begin
            if (addr_q == ADDRESSWIDTH'(k)) begin
                rd_word = reg_data_out[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes decode only flopped state, so they cannot glitch.
    always_comb begin
        state_d      = state_q;
        req_ready    = '0;
        reg_write_en = '0;
        reg_read_en  = '0;
        resp_valid   = '0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req_ready[grant_id] = 1'b1;
                    state_d             = ACCESS;
                end
            end
            ACCESS: begin
                if (in_range) begin
                    if (wr_q) begin
                        reg_write_en = REGS'(1) << addr_q;
                    end else begin
                        reg_read_en = REGS'(1) << addr_q;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                resp_valid[gid_q] = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Write data only moves on an accepted write, so reg_data_in holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            gid_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            resp_q  <= '0;
        end else begin
            if (handshake) begin
                gid_q  <= grant_id;
                wr_q   <= req_write[grant_id];
                addr_q <= sel_addr;
                if (req_write[grant_id]) begin
                    wdata_q <= sel_wdata;
                end
            end
            if (state_q == ACCESS) begin
                resp_q.err   <= ~in_range;
                resp_q.rdata <= (in_range && !wr_q) ? rd_word : '0;
            end
        end
    end

    assign reg_data_in = wdata_q;
    assign resp_rdata  = resp_q.rdata;
    assign resp_err    = resp_q.err;

endmodule

// File: tb/tb_i2c_reg_access_arbiter.sv
// Scoreboard bench for the register-port arbiter: a cycle model predicts ready,
// strobes and responses; expected responses queue at handshake and pop on resp_valid.
module tb_i2c_reg_access_arbiter;

    localparam int REGS = 9;
    localparam int AW   = 4;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0]        req_write = '0;
    logic [3:0]        a0 = '0, a1 = '0;
    logic [31:0]       wd0 = '0, wd1 = '0;
    logic [1:0]        resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [31:0]       reg_data_in;
    logic [REGS-1:0]   reg_write_en;
    logic [REGS-1:0]   reg_read_en;
    logic [REGS*32-1:0] reg_data_out;
    logic [31:0]       rf [REGS];

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    int   grant_log[$];
    int   resp_cnt[2] = '{0, 0};

    bit          mon_on = 1'b0;
    int          m_stage = 0;
    int          m_ptr = 0;
    int          m_id = 0;
    logic        m_wr = 1'b0;
    int          m_addr = 0;
    logic [31:0] m_last_wd = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < REGS; k++) reg_data_out[k*32 +: 32] = rf[k];
    end

    i2c_reg_access_arbiter #(.REGS(REGS), .ADDRESSWIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     ({a1, a0}),
        .req_wdata    ({wd1, wd0}),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .reg_data_in  (reg_data_in),
        .reg_write_en (reg_write_en),
        .reg_read_en  (reg_read_en),
        .reg_data_out (reg_data_out)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Cycle model, evaluated mid-cycle against what the next rising edge will see.
    logic [1:0]      e_rdy, e_rv;
    logic [REGS-1:0] e_we, e_re;
    int              g;
    exp_t            e;
    always @(negedge clk) begin
        if (mon_on) begin
            e_rdy = '0;
            g = -1;
            if (m_stage == 0) begin
                case (req_valid)
                    2'b01: g = 0;
                    2'b10: g = 1;
                    2'b11: g = m_ptr;
                    default: g = -1;
                endcase
                if (g >= 0) e_rdy[g] = 1'b1;
            end
            check_val("req_ready", 64'(req_ready), 64'(e_rdy));

            e_we = '0;
            e_re = '0;
            if (m_stage == 1 && m_addr < REGS) begin
                if (m_wr) e_we[m_addr] = 1'b1;
                else      e_re[m_addr] = 1'b1;
            end
            check_val("reg_write_en", 64'(reg_write_en), 64'(e_we));
            check_val("reg_read_en", 64'(reg_read_en), 64'(e_re));
            check_val("reg_data_in", 64'(reg_data_in), 64'(m_last_wd));

            e_rv = (m_stage == 2) ? (2'b01 << m_id) : 2'b00;
            check_val("resp_valid", 64'(resp_valid), 64'(e_rv));

            if (resp_valid != 2'b00) begin
                if (resp_valid[0]) resp_cnt[0]++;
                if (resp_valid[1]) resp_cnt[1]++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_val("resp_id", 64'(resp_valid), 64'(2'b01 << e.id));
                    check_val("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                    check_val("resp_err", 64'(resp_err), 64'(e.err));
                end else begin
                    check_val("resp_spurious", 64'(resp_valid), 64'(0));
                end
            end

            if (reset) begin
                m_stage   = 0;
                m_ptr     = 0;
                m_last_wd = '0;
                sb.delete();
            end else begin
                case (m_stage)
                    0: if (g >= 0) begin
                        m_id   = g;
                        m_wr   = req_write[g];
                        m_addr = (g == 1) ? int'(a1) : int'(a0);
                        e.id   = g;
                        e.err  = (m_addr >= REGS);
                        e.rdata = (!m_wr && m_addr < REGS) ? rf[m_addr] : 32'h0;
                        sb.push_back(e);
                        grant_log.push_back(g);
                        if (m_wr) m_last_wd = (g == 1) ? wd1 : wd0;
                        m_stage = 1;
                    end
                    1: m_stage = 2;
                    default: begin
                        m_ptr   = 1 - m_id;
                        m_stage = 0;
                    end
                endcase
            end
        end
    end

    task automatic set_req(input int id, input logic wr, input logic [3:0] addr, input logic [31:0] wd);
        if (id == 0) begin a0 = addr; wd0 = wd; end
        else         begin a1 = addr; wd1 = wd; end
        req_write[id] = wr;
        req_valid[id] = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; holds the request until ready, then drains.
    task automatic do_req(input int id, input logic wr, input logic [3:0] addr, input logic [31:0] wd);
        bit hs;
        hs = 1'b0;
        set_req(id, wr, addr, wd);
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            if (req_ready[id]) hs = 1'b1;
        end
        check_val("handshake", 64'(hs), 64'(1));
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        drain();
    endtask

    task automatic wait_grants(input int target);
        int n;
        n = 0;
        while (grant_log.size() < target && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("grant_count", 64'(grant_log.size()), 64'(target));
    endtask

    int base;
    int r1;

    initial begin
        for (int k = 0; k < REGS; k++) rf[k] = 32'hA000_0000 + 32'(k) * 32'h0101_1111;
        rf[5] = 32'h1234_5678;

        repeat (2) @(posedge clk);
        #1;
        mon_on = 1'b1;
        @(negedge clk);
        check_val("rst_req_ready", 64'(req_ready), 64'(0));
        check_val("rst_resp_valid", 64'(resp_valid), 64'(0));
        check_val("rst_resp_rdata", 64'(resp_rdata), 64'(0));
        check_val("rst_resp_err", 64'(resp_err), 64'(0));
        check_val("rst_write_en", 64'(reg_write_en), 64'(0));
        check_val("rst_read_en", 64'(reg_read_en), 64'(0));
        check_val("rst_data_in", 64'(reg_data_in), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Write from requester 0, then read from requester 1.
        do_req(0, 1'b1, 4'd3, 32'hDEAD_BEEF);
        do_req(1, 1'b0, 4'd5, 32'h0);
        check_val("resp_cnt1_after_read", 64'(resp_cnt[1]), 64'(1));

        // Continuous requests from both: grants must alternate starting at 0.
        base = grant_log.size();
        set_req(0, 1'b1, 4'd1, 32'h1111_0000);
        set_req(1, 1'b0, 4'd8, 32'h2222_0000);
        wait_grants(base + 4);
        req_valid = 2'b00;
        drain();
        for (int i = 0; i < 4; i++) check_val("rr_order", 64'(grant_log[base + i]), 64'(i % 2));

        // Out-of-range read.
        do_req(0, 1'b0, 4'd12, 32'h0);

        // Reset during ACCESS of a write abandons it; pointer returns to 0.
        set_req(0, 1'b1, 4'd2, 32'hCAFE_F00D);
        wait_grants(grant_log.size() + 1);
        req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_resp_valid", 64'(resp_valid), 64'(0));
        check_val("post_rst_write_en", 64'(reg_write_en), 64'(0));
        check_val("post_rst_data_in", 64'(reg_data_in), 64'(0));
        check_val("post_rst_rdata", 64'(resp_rdata), 64'(0));
        @(posedge clk);
        #1;
        base = grant_log.size();
        set_req(0, 1'b0, 4'd4, 32'h0);
        set_req(1, 1'b0, 4'd6, 32'h0);
        wait_grants(base + 1);
        req_valid = 2'b00;
        drain();
        check_val("first_after_rst", 64'(grant_log[base]), 64'(0));

        // Requester 1 raises valid only while requester 0 is in service.
        base = grant_log.size();
        r1 = resp_cnt[1];
        set_req(0, 1'b1, 4'd7, 32'h0BAD_F00D);
        wait_grants(base + 1);
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 4'd0, 32'h5555_AAAA);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check_val("drop_grants", 64'(grant_log.size() - base), 64'(1));
        check_val("drop_no_resp1", 64'(resp_cnt[1]), 64'(r1));

        // Random mix of reads, writes and out-of-range addresses.
        for (int i = 0; i < 30; i++) begin
            do_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0t exp=<200000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2c_reg_access_arbiter.md
Name: i2c_reg_access_arbiter

Overview:
- Shares the I2C peripheral's register-file port between two requesters: requester 0 is the host bus slave and requester 1 is the debug/self-test port.
- Accepts one request at a time using round-robin arbitration.
- Drives a single-cycle one-hot write or read strobe plus write data into the register file, captures the selected register's read data, and returns a response to the granted requester.
- Sits between the bus bridge and the register block, on the register side of the register interface.

Parameters:
- REGS, 9, number of implemented registers; width of the strobe vectors and count of read-data words.
- ADDRESSWIDTH, $clog2(REGS), width of the request address.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; a request transfers when valid and ready are both high.
- req_write  input  2  per-requester operation: 1 = write, 0 = read.
- req_addr  input  2*ADDRESSWIDTH  per-requester register index; requester i uses slice i.
- req_wdata  input  2*32  per-requester write data.
- resp_valid  output  2  per-requester response pulse, 1 cycle.
- resp_rdata  output  32  read data, shared by both requesters; qualified by resp_valid.
- resp_err  output  1  address-out-of-range flag; qualified by resp_valid.
- reg_data_in  output  32  write data to the register file.
- reg_write_en  output  REGS  one-hot write strobe.
- reg_read_en  output  REGS  one-hot read strobe.
- reg_data_out  input  REGS*32  register read data; word k is bits [32k+31:32k].

Behaviour:
- Clock and reset: single clock `clk`. Reset `reset` is synchronous and active-high.
- State machine: IDLE -> ACCESS -> RESP -> IDLE. Held in a state register; reset forces IDLE.
- Reset values:
  - req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - reg_write_en = 0, reg_read_en = 0, reg_data_in = 0.
  - Round-robin pointer selects requester 0 first.
- IDLE:
  - If no req_valid bit is set, remain in IDLE.
  - If exactly one bit is set, grant that requester.
  - If both are set, grant the requester named by the pointer.
  - req_ready is combinational and high only for the granted requester, only in IDLE, for exactly one cycle.
  - On the handshake, latch grant id, write flag, addr and wdata, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - If latched addr < REGS:
    - Write: assert reg_write_en[addr] and drive reg_data_in = wdata.
    - Read: assert reg_read_en[addr]; capture reg_data_out[addr] into the response register at the end of the cycle.
  - If addr >= REGS: no strobe is asserted; set err = 1 and rdata = 0.
  - Strobes are decoded from registered state, so they are glitch-free and one-hot or zero.
  - Go to RESP.
- RESP (1 cycle):
  - resp_valid[grant] = 1.
  - resp_rdata = captured data; forced to 0 for writes.
  - resp_err = err.
  - Pointer moves to the non-granted requester.
  - Go to IDLE.
- Latency: handshake in cycle N, strobe in N+1, response in N+2. Next accept no earlier than N+3. Peak throughput is one access per 3 cycles.
- Fairness: under continuous requests from both requesters, grants alternate 0, 1, 0, 1, ...
- Requester obligations:
  - Hold valid, write, addr and wdata stable until ready is seen.
  - Dropping valid before ready is permitted; the request is then simply never granted.
- reg_data_in holds its last value outside ACCESS; it is meaningful only when reg_write_en is asserted.
- Reset during ACCESS or RESP: the transaction is abandoned. The next cycle is IDLE with all outputs zero and no response issued. A strobe already driven in the reset cycle is covered by the register file's own reset.

Decomposition:
- Package i2c_reg_arb_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - NUM_REQ = 2, DATA_WIDTH = 32.
  - Response struct {rdata, err}.
- Sub-module rr_arbiter2: 2-input round-robin grant with pointer update on an enable input. Pure grant logic plus the pointer flop.

Test Plan:
- Reset, then requester 0 writes 0xDEADBEEF to addr 3 -> req_ready[0] 1 cycle; next cycle reg_write_en = 9'b000001000 and reg_data_in = 0xDEADBEEF; next cycle resp_valid[0] = 1 and resp_err = 0.
- reg_data_out word 5 = 0x12345678; requester 1 reads addr 5 -> reg_read_en[5] for 1 cycle; then resp_valid[1] = 1 and resp_rdata = 0x12345678.
- Both requesters hold valid for 4 transactions -> grant order 0, 1, 0, 1; no strobe asserted in IDLE or RESP.
- Requester 0 reads addr 12 (>= REGS) -> no strobe during ACCESS; resp_err = 1 and resp_rdata = 0.
- Reset asserted in the ACCESS cycle of a write -> no resp_valid follows; all outputs 0 the following cycle; the first request after reset goes to requester 0 when both are valid.
- Requester 1 raises valid then drops it before grant while requester 0 is being served -> requester 1 never gets ready or resp_valid; requester 0 completes normally.
